// File: rtl/multicycle_controller_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states and control-field encodings shared by the RV32 controllers.
package riscv_ctrl_pkg;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, BRANCH, TRAP
    } state_t;

    typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_FUNCT} alu_op_t;
    typedef enum logic [1:0] {SRC_A_PC, SRC_A_OLDPC, SRC_A_RS1} src_a_t;
    typedef enum logic [1:0] {SRC_B_RS2, SRC_B_FOUR, SRC_B_IMM} src_b_t;
    typedef enum logic [1:0] {CAUSE_NONE, CAUSE_ILLEGAL, CAUSE_TIMEOUT} cause_t;

    function automatic logic is_mem_state(state_t s);
        return s inside {FETCH, MEM_RD, MEM_WR};
    endfunction
endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: control and memory-handshake bundle between controller and datapath.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ack;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_to_reg;
    logic       instr_done;
    logic       trap;
    logic [1:0] trap_cause;

    modport master(
        input  opcode, zero, mem_ack,
        output mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, reg_write, mem_to_reg, instr_done, trap, trap_cause
    );
    modport slave(
        output opcode, zero, mem_ack,
        input  mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b,
               alu_op, reg_write, mem_to_reg, instr_done, trap, trap_cause
    );
endinterface

// File: rtl/multicycle_controller_mem_wait_timer.sv
// mem_wait_timer: counts unacknowledged cycles of one memory access and flags the timeout boundary.
module mem_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic ack,
    output logic expired
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt_d   = clear ? '0 : ack ? cnt_q : cnt_q + 1'b1;
    // A late ack on the boundary cycle still completes the access.
    assign expired = !ack && cnt_q == CNT_W'(TIMEOUT - 1);

    always_ff @(posedge clk or posedge reset)
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: per-state control for a shared-memory multicycle RV32 datapath
// with a mem_ack watchdog and a sticky trap.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input logic clk,
    input logic reset,
    multicycle_controller_if.master bus
);
    state_t state_q, state_d;
    cause_t cause_q, cause_d;
    logic   expired, clear;

    // The wait counter only runs while sitting in one memory state.
    assign clear = !is_mem_state(state_q) || state_d != state_q;

    mem_wait_timer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_timer (
        .clk(clk), .reset(reset), .clear(clear), .ack(bus.mem_ack), .expired(expired)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state_q <= IDLE;
            cause_q <= CAUSE_NONE;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
        end

    always_comb begin
        state_d        = state_q;
        cause_d        = cause_q;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.pc_write   = 1'b0;
        bus.pc_src     = 1'b0;
        bus.alu_src_a  = SRC_A_PC;
        bus.alu_src_b  = SRC_B_RS2;
        bus.alu_op     = ALU_ADD;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.instr_done = 1'b0;
        bus.trap       = state_q == TRAP;
        bus.trap_cause = cause_q;
        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = SRC_B_FOUR;
                bus.ir_write  = bus.mem_ack;
                bus.pc_write  = bus.mem_ack;
                state_d       = bus.mem_ack ? DECODE : expired ? TRAP : FETCH;
            end
            DECODE: begin
                bus.alu_src_a = SRC_A_OLDPC;
                bus.alu_src_b = SRC_B_IMM;
                state_d = bus.opcode == OP_RTYPE ? EXEC_R :
                          bus.opcode inside {OP_LOAD, OP_STORE} ? ADDR :
                          bus.opcode == OP_BRANCH ? BRANCH : TRAP;
            end
            EXEC_R: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_op    = ALU_FUNCT;
                state_d       = WB_R;
            end
            WB_R: begin
                bus.reg_write  = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end
            ADDR: begin
                bus.alu_src_a = SRC_A_RS1;
                bus.alu_src_b = SRC_B_IMM;
                state_d       = bus.opcode == OP_LOAD ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
                state_d      = bus.mem_ack ? WB_LD : expired ? TRAP : MEM_RD;
            end
            WB_LD: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end
            MEM_WR: begin
                bus.mem_write  = 1'b1;
                bus.iord       = 1'b1;
                bus.instr_done = bus.mem_ack;
                state_d        = bus.mem_ack ? FETCH : expired ? TRAP : MEM_WR;
            end
            BRANCH: begin
                bus.alu_src_a  = SRC_A_RS1;
                bus.alu_op     = ALU_SUB;
                bus.pc_src     = 1'b1;
                bus.pc_write   = bus.zero;
                bus.instr_done = 1'b1;
                state_d        = FETCH;
            end
            TRAP: state_d = TRAP;
            default: state_d = IDLE;
        endcase
        if (state_d == TRAP && state_q != TRAP)
            cause_d = state_q == DECODE ? CAUSE_ILLEGAL : CAUSE_TIMEOUT;
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: randomized instruction stream checked against a per-instruction cost model.
module tb_multicycle_controller;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam int NEVER = 1000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    multicycle_controller_if bus();
    multicycle_controller #(.TIMEOUT(16), .CNT_W(5)) dut(.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int passed = 0, total = 0;
    int fetch_wait = 0, data_wait = 0, req_cnt = 0;
    logic prev_req = 1'b0, prev_iord = 1'b0;
    int cyc = 0, n_rw = 0, n_mw = 0, n_iord = 0, n_pcw = 0, n_irw = 0, n_m2r = 0, n_pcsrc = 0, n_trap = 0, n_done = 0;
    event sampled;

    function automatic logic [17:0] outs();
        return {bus.mem_read, bus.mem_write, bus.iord, bus.ir_write, bus.pc_write, bus.pc_src,
                bus.alu_src_a, bus.alu_src_b, bus.alu_op, bus.reg_write, bus.mem_to_reg,
                bus.instr_done, bus.trap, bus.trap_cause};
    endfunction

    function automatic logic [4:0] enables();
        return {bus.reg_write, bus.mem_write, bus.pc_write, bus.ir_write, bus.mem_read};
    endfunction

    // Memory responder acks the N-th request cycle of each access; then per-cycle activity is tallied.
    always @(negedge clk) begin
        logic req;
        req = bus.mem_read | bus.mem_write;
        if (req && (!prev_req || prev_iord != bus.iord)) begin
            req_cnt = 0;
            if (!bus.iord) begin
                cyc = 0; n_rw = 0; n_mw = 0; n_iord = 0; n_pcw = 0;
                n_irw = 0; n_m2r = 0; n_pcsrc = 0; n_trap = 0; n_done = 0;
            end
        end else if (req) req_cnt++;
        prev_req = req;
        prev_iord = bus.iord;
        bus.mem_ack = req && req_cnt == (bus.iord ? data_wait : fetch_wait);
        #1;
        cyc++;
        n_rw += int'(bus.reg_write);
        n_mw += int'(bus.mem_write);
        n_iord += int'(bus.iord);
        n_pcw += int'(bus.pc_write);
        n_irw += int'(bus.ir_write);
        n_m2r += int'(bus.mem_to_reg && bus.reg_write);
        n_pcsrc += int'(bus.pc_src);
        n_trap += int'(bus.trap);
        n_done += int'(bus.instr_done);
        -> sampled;
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(sampled);
        @(negedge clk);
        reset = 1'b0;
        @(sampled);
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(sampled);
            if (bus.instr_done) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic z, input int fw, input int dw);
        bit ok;
        bit is_r = opc == OP_R;
        bit is_ld = opc == OP_LD;
        bit is_st = opc == OP_ST;
        bit is_br = opc == OP_BR;
        int exp_v[9];
        int got_v[9];
        string nm[9] = '{"latency", "reg_write", "mem_write", "iord", "pc_write", "ir_write", "mem_to_reg", "pc_src", "trap"};
        exp_v[0] = is_r ? fw + 4 : is_ld ? fw + dw + 5 : is_st ? fw + dw + 4 : fw + 3;
        exp_v[1] = (is_r || is_ld) ? 1 : 0;
        exp_v[2] = is_st ? dw + 1 : 0;
        exp_v[3] = (is_ld || is_st) ? dw + 1 : 0;
        exp_v[4] = (is_br && z) ? 2 : 1;
        exp_v[5] = 1;
        exp_v[6] = is_ld ? 1 : 0;
        exp_v[7] = is_br ? 1 : 0;
        exp_v[8] = 0;
        bus.opcode = opc;
        bus.zero = z;
        fetch_wait = fw;
        data_wait = dw;
        wait_done(100, ok);
        total++;
        if (!ok) begin
            $display("FAIL instr_done opcode=%b: no retirement within 100 cycles", opc);
            return;
        end
        passed++;
        got_v = '{cyc, n_rw, n_mw, n_iord, n_pcw, n_irw, n_m2r, n_pcsrc, n_trap};
        for (int i = 0; i < 9; i++) begin
            total++;
            if (got_v[i] !== exp_v[i])
                $display("FAIL %s opcode=%b fw=%0d dw=%0d: got %0d expected %0d", nm[i], opc, fw, dw, got_v[i], exp_v[i]);
            else passed++;
        end
    endtask

    task automatic test_reset();
        bus.opcode = OP_R;
        bus.zero = 1'b0;
        fetch_wait = 0;
        data_wait = 0;
        repeat (3) @(sampled);
        total++;
        if (outs() !== 18'd0) $display("FAIL reset_outputs: got %h expected 0", outs());
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        @(sampled);
        total++;
        if (outs() !== 18'd0) $display("FAIL idle_outputs: got %h expected 0", outs());
        else passed++;
    endtask

    task automatic test_rtype();
        run_instr(OP_R, 1'b0, 0, 0);
    endtask

    task automatic test_load();
        run_instr(OP_LD, 1'b0, 3, 2);
    endtask

    task automatic test_branch();
        run_instr(OP_BR, 1'b1, 1, 0);
        run_instr(OP_BR, 1'b0, 0, 0);
    endtask

    task automatic test_illegal();
        logic [6:0] bad[4] = '{7'b0010011, 7'b0110111, 7'b1101111, 7'b0000000};
        bit seen = 1'b0;
        int bad_cycles = 0;
        bus.opcode = bad[$urandom_range(0, 3)];
        fetch_wait = $urandom_range(0, 4);
        for (int i = 0; i < 40 && !seen; i++) begin
            @(sampled);
            seen = bus.alu_src_a == 2'b01;
        end
        total++;
        if (!seen) $display("FAIL illegal_decode: DECODE not reached within 40 cycles");
        else passed++;
        @(sampled);
        total++;
        if ({bus.trap, bus.trap_cause} !== 3'b101) $display("FAIL illegal_trap: got %b expected 101", {bus.trap, bus.trap_cause});
        else passed++;
        for (int i = 0; i < 20; i++) begin
            @(sampled);
            if (enables() != 5'd0 || !bus.trap || bus.trap_cause != 2'b01) bad_cycles++;
        end
        total++;
        if (bad_cycles !== 0) $display("FAIL illegal_hold: got %0d bad cycles expected 0", bad_cycles);
        else passed++;
        fetch_wait = 0;
        do_reset();
    endtask

    task automatic test_timeout();
        bit seen = 1'b0;
        bus.opcode = OP_ST;
        fetch_wait = 0;
        data_wait = NEVER;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(sampled);
            seen = bus.trap;
        end
        total++;
        if (!seen) $display("FAIL timeout_trap: no trap within 60 cycles");
        else passed++;
        total++;
        if (n_mw !== 16) $display("FAIL timeout_mem_write: got %0d cycles expected 16", n_mw);
        else passed++;
        total++;
        if ({enables(), bus.trap_cause, n_done} !== {5'd0, 2'b10, 32'd0})
            $display("FAIL timeout_entry: enables=%b cause=%b done=%0d expected 00000 10 0", enables(), bus.trap_cause, n_done);
        else passed++;
        do_reset();
        run_instr(OP_ST, 1'b0, 0, 15);
        run_instr(OP_LD, 1'b0, 15, 15);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        bus.opcode = OP_ST;
        fetch_wait = 0;
        data_wait = NEVER;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(sampled);
            seen = bus.mem_write;
        end
        repeat (3) @(sampled);
        reset = 1'b1;
        #1;
        total++;
        if ({seen, outs()} !== {1'b1, 18'd0}) $display("FAIL reset_async: seen=%b outs=%h expected 1 0", seen, outs());
        else passed++;
        @(sampled);
        @(negedge clk);
        reset = 1'b0;
        @(sampled);
        total++;
        if (outs() !== 18'd0) $display("FAIL reset_idle: got %h expected 0", outs());
        else passed++;
        @(sampled);
        total++;
        if ({bus.mem_read, bus.iord, bus.alu_src_b} !== 4'b1001)
            $display("FAIL reset_fetch: got %b expected 1001", {bus.mem_read, bus.iord, bus.alu_src_b});
        else passed++;
        do_reset();
    endtask

    task automatic test_back_to_back();
        logic [6:0] ops[4] = '{OP_R, OP_LD, OP_ST, OP_BR};
        for (int i = 0; i < 40; i++)
            run_instr(ops[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom_range(0, 15));
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        test_reset();
        test_rtype();
        test_load();
        test_branch();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore/Mealy FSM that sequences a shared-memory multicycle RV32 datapath (single ALU, single instruction/data memory port) for R-type, load, store and beq.
- Sits beside the datapath and replaces single-cycle decode with per-state control.
- Adds a request/acknowledge memory handshake with a timeout watchdog.
- Flags illegal opcodes and memory timeouts as a sticky trap.

Parameters:
- TIMEOUT, 16, maximum cycles spent waiting for mem_ack in one memory state before trapping (must be >=2).
- CNT_W, 5, width of the wait counter (must hold TIMEOUT).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- opcode  in  7  instr[6:0] from instruction register, valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ack  in  1  memory completes the current read/write this cycle
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- iord  out  1  address select: 0=PC, 1=ALUOut
- ir_write  out  1  load IR and OldPC
- pc_write  out  1  PC update enable
- pc_src  out  1  PC source: 0=ALU result, 1=ALUOut
- alu_src_a  out  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
- alu_src_b  out  2  ALU B select: 00=rs2, 01=constant 4, 10=immediate
- alu_op  out  2  00=add, 01=subtract/compare, 10=funct-decoded
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  write-back select: 0=ALUOut, 1=MDR
- instr_done  out  1  one-cycle pulse when an instruction retires
- trap  out  1  sticky fault flag
- trap_cause  out  2  00=none, 01=illegal opcode, 10=memory timeout

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC_R, WB_R, ADDR, MEM_RD, WB_LD, MEM_WR, BRANCH, TRAP.
- Reset:
  - State goes to IDLE; wait counter = 0; trap = 0; trap_cause = 00.
  - All control outputs are 0 in IDLE; alu_src_a, alu_src_b and alu_op = 00.
  - Reset asserted mid-instruction aborts immediately; no partial write enables are asserted afterwards.
- IDLE: unconditionally goes to FETCH on the next cycle.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=00, alu_src_b=01, alu_op=00.
  - ir_write and pc_write are asserted combinationally only in the cycle where mem_ack=1 (Mealy); pc_src=0.
  - On ack, next state is DECODE.
- DECODE:
  - Drives alu_src_a=01, alu_src_b=10, alu_op=00, so ALUOut = branch target.
  - Next state from opcode: 0110011 -> EXEC_R; 0000011 or 0100011 -> ADDR; 1100011 -> BRANCH.
  - Any other opcode -> TRAP with cause 01.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; next state WB_R.
- WB_R: reg_write=1, mem_to_reg=0, instr_done=1; next state FETCH.
- ADDR: alu_src_a=10, alu_src_b=10, alu_op=00; next state MEM_RD for loads, MEM_WR for stores (opcode re-examined).
- MEM_RD: mem_read=1, iord=1; on ack, next state WB_LD.
- WB_LD: reg_write=1, mem_to_reg=1, instr_done=1; next state FETCH.
- MEM_WR: mem_write=1, iord=1; on ack, instr_done=1 and next state FETCH.
- BRANCH:
  - Drives alu_src_a=10, alu_src_b=00, alu_op=01, pc_src=1.
  - pc_write = zero (combinational); instr_done=1; next state FETCH.
- Memory wait (FETCH, MEM_RD, MEM_WR):
  - Counter clears on entry to each memory state and increments each cycle mem_ack=0.
  - If mem_ack is still 0 in the cycle the counter equals TIMEOUT-1, next state is TRAP with cause 10; request outputs drop in TRAP.
  - mem_ack in the same cycle as the timeout boundary wins: the access completes and no trap is raised.
- mem_ack outside a memory state is ignored.
- TRAP: all enables are 0; trap=1 and trap_cause are held until reset; the controller makes no further progress.
- Write enables (reg_write, mem_write, pc_write, ir_write) are never asserted in the same cycle as trap entry.

Decomposition:
- Shared package riscv_ctrl_pkg holds:
  - opcode constants (OP_RTYPE, OP_LOAD, OP_STORE, OP_BRANCH);
  - the state enum;
  - alu_op, alu_src_a/alu_src_b and trap_cause encodings.
- The single-cycle control decoder imports the same opcode and alu_op constants from this package.
- One sub-module, mem_wait_timer:
  - inputs: clk, reset, clear, ack;
  - output: expired;
  - parameterised by TIMEOUT and CNT_W.

Test Plan:
- Reset release, then R-type (0110011) with mem_ack on the first FETCH cycle -> states IDLE, FETCH, DECODE, EXEC_R, WB_R; reg_write=1 and instr_done=1 in cycle 5; ir_write/pc_write pulse exactly once.
- Load with FETCH ack after 3 wait cycles and MEM_RD ack after 2 -> iord=1 only in MEM_RD; mem_to_reg=1 with reg_write in WB_LD; 10 cycles from FETCH entry to instr_done.
- beq with zero=1, then beq with zero=0 -> pc_write=1, pc_src=1 in BRANCH for the first; pc_write=0 for the second; both pulse instr_done.
- Opcode 0010011 in DECODE -> TRAP next cycle; trap=1, trap_cause=01; all enables 0 for 20 following cycles.
- Store with mem_ack held 0 and TIMEOUT=16 -> mem_write high for 16 cycles, then TRAP with cause 10. Repeat with ack arriving on the 16th cycle -> no trap; instr_done=1.
- Assert reset during MEM_WR -> mem_write drops asynchronously; outputs are at IDLE values; trap=0; FETCH resumes one cycle after reset deasserts.
